div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Parametrised multi-cycle integer divider for the EX stage; serves DIV/DIVU, produces {remainder, quotient} for the HI/LO path.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- While busy it holds a stall request so EX stalls and the earlier pipeline stages freeze.
- Supersedes the single-width divider; adds width parametrisation, a zero-divisor fast path, annul (flush) and an early-out option.

Parameters:
- WIDTH, 32, operand width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
- opdata1_i  input  WIDTH  dividend; sampled with start_i.
- opdata2_i  input  WIDTH  divisor; sampled with start_i.
- start_i  input  1  request a division; held high by EX until ready_o is seen.
- annul_i  input  1  flush; aborts any operation in progress.
- result_o  output  2*WIDTH  {remainder[2*WIDTH-1:WIDTH], quotient[WIDTH-1:0]}.
- ready_o  output  1  result_o valid this cycle.
- stallreq_o  output  1  divider busy; EX must stall.

Behaviour:
- Reset (async): state=FREE; result_o=0; ready_o=0; stallreq_o=0; counter and datapath registers cleared.
- FREE:
  - start_i=1 and annul_i=0 and divisor==0 -> DIVZERO.
  - start_i=1 and annul_i=0 and divisor!=0 -> ON. On this transition: latch |dividend|, |divisor| (absolute values only if signed_div_i=1), both operand sign bits and signed_div_i; counter=0; partial remainder=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- DIVZERO: next cycle -> END with result_o=0.
- ON, each cycle:
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor.
  - If no borrow: rem = difference, quotient bit = 1; else quotient bit = 0.
  - counter increments. After WIDTH iterations -> END.
  - Sign fix on entry to END: quotient negated if dividend and divisor signs differ; remainder takes the dividend's sign (signed mode only).
- END: ready_o=1 and result_o valid. Next state is FREE when start_i=0; otherwise stay in END, holding ready_o=1 and result_o stable.
- stallreq_o=1 iff (FREE and start_i and !annul_i) or ON or DIVZERO. It is 0 in END so the pipeline advances in the same cycle ready_o is seen.
- Latency from the start_i sample to ready_o: WIDTH+1 cycles normally, 2 cycles for a zero divisor.
- annul_i=1 in any state -> FREE next cycle; ready_o=0 and stallreq_o=0 from that cycle on; no result is produced. annul_i has priority over start_i.
- Signed overflow (MIN_INT / -1): quotient=MIN_INT (wraps), remainder=0; no trap.
- Operand changes after sampling are ignored until the FSM returns to FREE.
- All arithmetic is modulo 2^WIDTH, with a WIDTH+1-bit trial subtractor.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, when divisor!=0 and |dividend| < |divisor| (unsigned compare of the magnitudes), go directly to END with quotient=0 and remainder=dividend (original signed value). Latency is 2 cycles.
- Undefined: every nonzero-divisor operation takes the full WIDTH+1 cycles. Results are identical either way.

Decomposition:
- Shared package div_pkg holds:
  - State encoding: FREE, DIVZERO, ON, END (2-bit).
  - DivResultReady / DivResultNotReady constants.
  - DivStart / DivStop constants.
  - A helper function computing the two's-complement absolute value.
- One sub-module, div_step: a combinational single restoring iteration. Inputs are {rem, dividend} and divisor; outputs are the next {rem, dividend} and the quotient bit. It is instantiated once and iterated by the FSM.

Test Plan:
- WIDTH=32, unsigned 100/7: start held -> ready_o after 33 cycles; result_o={32'd2, 32'd14}; stallreq_o high for 33 cycles, low in END.
- Signed -7/2: quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7/-2: quotient -3, remainder +1.
- Divisor 0 (signed and unsigned): ready_o 2 cycles after start; result_o=0. Also 0x80000000/-1 signed -> quotient 0x80000000, remainder 0.
- annul_i pulsed at iteration 10: FSM returns to FREE, ready_o never asserts; a new start next cycle gives the correct 1000/10 -> {0, 100}.
- start_i held 3 cycles after ready_o: result_o stable and ready_o=1 throughout; FREE on start_i deassert. Async rst mid-ON clears all outputs immediately, independent of clk.
- DIV_EARLY_OUT_EN defined: 5/9 -> {5, 0} in 2 cycles. Undefined: same result in 33 cycles. Also rerun at WIDTH=8: 200/3 unsigned -> {2, 66} in 9 cycles.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the radix-2 restoring divider (div_unit, div_step).
package div_pkg;

    // Largest operand width that the div_abs helper supports.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_FREE    = 2'b00,
        ST_DIVZERO = 2'b01,
        ST_ON      = 2'b10,
        ST_END     = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    // Two's-complement magnitude of a w-bit value that has been zero-extended to
    // DIV_MAX_W bits. The caller keeps only the low w bits, so MIN_INT maps to itself.
    function automatic logic [DIV_MAX_W-1:0] div_abs(input logic [DIV_MAX_W-1:0] v,
                                                     input int unsigned         w);
        logic [DIV_MAX_W-1:0] sign_sh;
        sign_sh = v >> (w - 1);
        return sign_sh[0] ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, dividend} left and trial-subtract.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_rd,
    input  logic [WIDTH-1:0]   i_divisor,
    output logic [2*WIDTH-1:0] o_rd,
    output logic               o_q_bit
);

    logic [WIDTH:0]   w_partial;
    logic [WIDTH+1:0] w_diff;

    // The partial remainder after the shift can need WIDTH+1 bits; the extra
    // top bit of the difference is the borrow.
    assign w_partial = i_rd[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_partial} - {2'b00, i_divisor};
    assign o_q_bit   = ~w_diff[WIDTH+1];

    // Bit 0 is left clear; the quotient bit is merged in by the caller.
    assign o_rd = o_q_bit ? {w_diff[WIDTH-1:0],    i_rd[WIDTH-2:0], 1'b0}
                          : {w_partial[WIDTH-1:0], i_rd[WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result_o = {remainder, quotient}.
// Define DIV_EARLY_OUT_EN to skip the iterations when |dividend| < |divisor|.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int RD_W  = 2 * WIDTH;

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [RD_W-1:0]  r_rd;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_hi;
    logic             r_sign1;
    logic             r_sign2;
    logic             r_signed;

    logic [WIDTH-1:0] w_mag1;
    logic [WIDTH-1:0] w_mag2;
    logic [RD_W-1:0]  w_step_rd;
    logic             w_q_bit;
    logic [RD_W-1:0]  w_rd_next;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_quo_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_mag1 = signed_div_i ? WIDTH'(div_abs(DIV_MAX_W'(opdata1_i), WIDTH)) : opdata1_i;
    assign w_mag2 = signed_div_i ? WIDTH'(div_abs(DIV_MAX_W'(opdata2_i), WIDTH)) : opdata2_i;

    div_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_rd      (r_rd),
        .i_divisor (r_divisor),
        .o_rd      (w_step_rd),
        .o_q_bit   (w_q_bit)
    );

    assign w_rd_next = w_step_rd | RD_W'(w_q_bit);
    assign w_quo     = w_rd_next[WIDTH-1:0];
    assign w_rem     = w_rd_next[RD_W-1:WIDTH];

    // Sign fix applied to the final iteration's output as it is registered into END.
    assign w_quo_fix = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quo : w_quo;
    assign w_rem_fix = (r_signed && r_sign1) ? -w_rem : w_rem;

    assign stallreq_o = ((r_state == ST_FREE) && (start_i == DivStart) && !annul_i)
                      || (r_state == ST_ON) || (r_state == ST_DIVZERO);

    // NOTE: every register here uses <= so all updates see the pre-edge values;
    // the datapath registers are reset too so result_o never exposes stale data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_FREE;
            r_cnt     <= '0;
            r_rd      <= '0;
            r_divisor <= '0;
            r_hi      <= '0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_signed  <= 1'b0;
            result_o  <= '0;
            ready_o   <= DivResultNotReady;
        end else if (annul_i) begin
            r_state  <= ST_FREE;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (r_state)
                ST_FREE: begin
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                    if (start_i == DivStart) begin
                        if (opdata2_i == '0) begin
                            r_state <= ST_DIVZERO;
                            r_hi    <= '0;
                        end
`ifdef DIV_EARLY_OUT_EN
                        // Early-out shares the one-cycle DIVZERO bubble, carrying the dividend as remainder.
                        else if (w_mag1 < w_mag2) begin
                            r_state <= ST_DIVZERO;
                            r_hi    <= opdata1_i;
                        end
`endif
                        else begin
                            r_state   <= ST_ON;
                            r_cnt     <= '0;
                            r_rd      <= {{WIDTH{1'b0}}, w_mag1};
                            r_divisor <= w_mag2;
                            r_sign1   <= opdata1_i[WIDTH-1];
                            r_sign2   <= opdata2_i[WIDTH-1];
                            r_signed  <= signed_div_i;
                        end
                    end
                end
                ST_DIVZERO: begin
                    r_state  <= ST_END;
                    result_o <= {r_hi, {WIDTH{1'b0}}};
                    ready_o  <= DivResultReady;
                end
                ST_ON: begin
                    r_rd  <= w_rd_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state  <= ST_END;
                        result_o <= {w_rem_fix, w_quo_fix};
                        ready_o  <= DivResultReady;
                    end
                end
                ST_END: begin
                    if (start_i == DivStop) begin
                        r_state  <= ST_FREE;
                        result_o <= '0;
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: begin
                    r_state  <= ST_FREE;
                    result_o <= '0;
                    ready_o  <= DivResultNotReady;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit at WIDTH=32 and WIDTH=8.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
    localparam int EO_LAT = 2;
`else
    localparam int EO_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;
    logic        stallreq;

    logic        signed_div8 = 1'b0;
    logic [7:0]  op1_8 = '0;
    logic [7:0]  op2_8 = '0;
    logic        start8 = 1'b0;
    logic        annul8 = 1'b0;
    logic [15:0] result8;
    logic        ready8;
    logic        stallreq8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div8),
        .opdata1_i    (op1_8),
        .opdata2_i    (op2_8),
        .start_i      (start8),
        .annul_i      (annul8),
        .result_o     (result8),
        .ready_o      (ready8),
        .stallreq_o   (stallreq8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Starts one 32-bit operation and leaves start high in END.
    task automatic run32(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
        int lat;
        int stalls;
        @(negedge clk);
        signed_div = sgn;
        op1 = a;
        op2 = b;
        start = 1'b1;
        #1;
        check({tag, "_stall_pre"}, stallreq, 1);
        lat = 0;
        stalls = 1;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                op1 = ~a;
                op2 = b + 32'd3;
            end
            if (ready) break;
            if (stallreq) stalls++;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_stall_cycles"}, stalls, exp_lat);
        check({tag, "_stall_end"}, stallreq, 0);
    endtask

    task automatic release_start(input string tag);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_rel_ready"}, ready, 0);
        check({tag, "_rel_result"}, result, 0);
        check({tag, "_rel_stall"}, stallreq, 0);
    endtask

    task automatic run8(input string tag, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        signed_div8 = sgn;
        op1_8 = a;
        op2_8 = b;
        start8 = 1'b1;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (ready8) break;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, result8, exp_res);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", ready, 0);
        check("reset_result", result, 0);
        check("reset_stall", stallreq, 0);
        @(negedge clk);
        rst = 1'b0;

        run32("udiv_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("hold_ready", ready, 1);
            check("hold_result", result, {32'd2, 32'd14});
            check("hold_stall", stallreq, 0);
        end
        release_start("udiv_100_7");

        run32("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        release_start("sdiv_m7_2");
        run32("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
        release_start("sdiv_7_m2");
        run32("udiv_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 64'h0000_0001_7FFF_FFFC, 33);
        release_start("udiv_big_2");
        run32("udiv_zero", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
        release_start("udiv_zero");
        run32("sdiv_zero", 1'b1, 32'hFFFF_FFF9, 32'd0, 64'd0, 2);
        release_start("sdiv_zero");
        run32("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);
        release_start("sdiv_ovf");
        run32("udiv_5_9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, EO_LAT);
        release_start("udiv_5_9");
        run32("sdiv_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9, 64'hFFFF_FFFB_0000_0000, EO_LAT);
        release_start("sdiv_m5_9");

        // Annul at iteration 10 with start still high; annul must win.
        seen = 0;
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd10;
        start = 1'b1;
        repeat (11) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        @(negedge clk);
        annul = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (ready) seen++;
        end
        check("annul_ready", ready, 0);
        check("annul_result", result, 0);
        check("annul_stall", stallreq, 0);
        check("annul_no_ready_seen", seen, 0);
        annul = 1'b0;
        start = 1'b0;
        run32("after_annul", 1'b0, 32'd1000, 32'd10, {32'd0, 32'd100}, 33);
        release_start("after_annul");

        // Asynchronous reset in the middle of ON.
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd10;
        start = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        check("rst_on_stall_before", stallreq, 1);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_on_stall", stallreq, 0);
        check("rst_on_ready", ready, 0);
        check("rst_on_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while END holds a nonzero result.
        run32("pre_rst_end", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        #3;
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_end_ready", ready, 0);
        check("rst_end_result", result, 0);
        @(negedge clk);
        rst = 1'b0;

        run8("w8_udiv_200_3", 1'b0, 8'd200, 8'd3, {8'd2, 8'd66}, 9);
        run8("w8_sdiv_ovf", 1'b1, 8'h80, 8'hFF, 16'h0080, 9);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
